mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the RV32I datapath.
- Latches the fetched instruction and decodes it into the datapath control bus (PC select, immediate select, register write, ALU and memory controls, write-back select).
- Gates the PC, register file and memory writes so that each instruction commits exactly once.
- Sits between the instruction memory output and the datapath control inputs. It also adds the PC write enable, the load/store wait handshake and illegal-instruction trapping.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles spent in MEM waiting for i_mem_ready before trapping (range 1..255).

Ports:
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_instr  in  32  instruction word from instruction memory at current PC
- i_br_lt  in  1  branch comparator less-than
- i_br_eq  in  1  branch comparator equal
- i_mem_ready  in  1  LSU access complete this cycle
- o_pc_en  out  1  PC register load enable
- o_pc_sel  out  1  0 = PC+4, 1 = ALU result
- o_imm_sel  out  4  0000 I, 0001 S, 0010 B, 0100 J, 1000 U
- o_reg_wen  out  1  register file write enable
- o_br_un  out  1  unsigned compare
- o_a_sel  out  1  0 = rs1, 1 = PC
- o_b_sel  out  1  0 = rs2, 1 = immediate
- o_lui_sel  out  1  force ALU operand A to zero
- o_alu_op  out  2  00 add, 01 R-type, 10 I-type ALU, 11 reserved
- o_load_type  out  4  0001 byte, 0011 half, 1111 word
- o_load_signed  out  1  sign-extend load data
- o_mem_rw  out  1  1 = store write
- o_wb_sel  out  2  00 load data, 01 ALU, 10 PC+4
- o_insn_vld  out  1  one-cycle pulse on instruction commit
- o_illegal  out  1  sticky trap flag
- o_state  out  3  current state (debug)

Behaviour:
- Clock and reset: one clock, i_clk. i_reset is asynchronous and active-high.
- Reset behaviour:
  - Asynchronous reset forces state FETCH, IR = 0, wait counter = 0 and o_illegal = 0.
  - All outputs are 0 while reset is asserted.
  - Reset mid-instruction abandons the instruction with no commit.
- States (o_state encoding): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- FETCH: IR <= i_instr at the clock edge, then go to DECODE. All enables are 0 in FETCH.
- Decode source: all mux selects, o_imm_sel, o_alu_op, o_br_un, o_load_type and o_load_signed are decoded combinationally from IR. They are valid and stable from DECODE through the commit cycle, and 0 in FETCH and TRAP.
- Write enables: o_reg_wen, o_mem_rw and o_pc_en are asserted only in the commit cycle, one cycle each. o_insn_vld pulses in the same cycle as o_pc_en.
- Sequences per instruction class:
  - R / I-ALU / LUI / AUIPC: FETCH, DECODE, EXEC, WB. WB drives reg_wen=1, wb_sel=01, pc_en=1, pc_sel=0. LUI uses lui_sel=1, b_sel=1, U imm. AUIPC uses a_sel=1, b_sel=1, U imm.
  - JAL / JALR: FETCH, DECODE, EXEC, WB. WB drives reg_wen=1, wb_sel=10, pc_sel=1, pc_en=1. JAL uses a_sel=1 with J imm; JALR uses a_sel=0 with I imm.
  - Branch: FETCH, DECODE, EXEC. EXEC drives a_sel=1, b_sel=1, B imm, pc_en=1 and pc_sel=taken.
  - Branch condition (funct3 = IR[14:12]): beq eq; bne !eq; blt lt; bge !lt; bltu/bgeu use lt/!lt with br_un=1. funct3 010/011 is illegal.
  - Load: FETCH, DECODE, EXEC, MEM (hold until i_mem_ready), WB. WB drives wb_sel=00, reg_wen=1, pc_en=1.
  - Store: FETCH, DECODE, EXEC, MEM. o_mem_rw=1 is held throughout MEM. The commit (pc_en=1) occurs in the MEM cycle in which i_mem_ready=1.
  - i_mem_ready is ignored outside MEM. If i_mem_ready is already 1 on MEM entry, MEM lasts exactly one cycle.
- Memory wait counter: counts cycles in MEM and clears on MEM exit. Reaching MEM_TIMEOUT without i_mem_ready moves the FSM to TRAP with no commit. For a store, o_mem_rw drops to 0 on that transition.
- Illegal instructions: an unknown opcode, or bad funct3 for loads, stores or branches, goes from DECODE to TRAP.
- TRAP: o_illegal=1, all enables 0. TRAP is left only by reset.

Test Plan:
- `add x3,x1,x2` (0x002081B3), i_mem_ready=0 -> states 0,1,2,4; reg_wen=1, wb_sel=01, alu_op=01, pc_en=1 only in cycle 4; o_insn_vld single pulse.
- `beq x1,x2,+8` (0x00208463) with i_br_eq=1, then i_br_eq=0 -> 3-cycle instruction; pc_sel=1, then 0; reg_wen never set.
- `lw x5,4(x1)` (0x0040A283), i_mem_ready asserted after 3 MEM cycles -> MEM held 3 cycles, load_type=1111, load_signed=1, then WB with wb_sel=00, reg_wen=1, pc_en=1.
- `sw` (0x0050A223), i_mem_ready held 0 -> mem_rw=1 for 16 cycles, then TRAP, o_illegal=1, no pc_en.
- IR=0xFFFFFFFF -> DECODE to TRAP, o_illegal stays 1; assert i_reset mid-TRAP -> immediate FETCH, all outputs 0.
- `lui x7,0x12345` (0x123453B7) -> lui_sel=1, b_sel=1, imm_sel=1000, wb_sel=01 in WB.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: latches the fetched instruction, decodes the
// datapath control bus and gates PC/register/memory writes so each instruction commits once.
module mc_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_instr,
    input  logic        i_br_lt,
    input  logic        i_br_eq,
    input  logic        i_mem_ready,
    output logic        o_pc_en,
    output logic        o_pc_sel,
    output logic [3:0]  o_imm_sel,
    output logic        o_reg_wen,
    output logic        o_br_un,
    output logic        o_a_sel,
    output logic        o_b_sel,
    output logic        o_lui_sel,
    output logic [1:0]  o_alu_op,
    output logic [3:0]  o_load_type,
    output logic        o_load_signed,
    output logic        o_mem_rw,
    output logic [1:0]  o_wb_sel,
    output logic        o_insn_vld,
    output logic        o_illegal,
    output logic [2:0]  o_state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_ir;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_next;
    logic        r_illegal;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_unused_ir;
    logic        w_taken;

    logic        w_is_br;
    logic        w_is_ld;
    logic        w_is_st;
    logic        w_bad;
    logic        w_dec_pc_sel;
    logic [3:0]  w_dec_imm_sel;
    logic        w_dec_br_un;
    logic        w_dec_a_sel;
    logic        w_dec_b_sel;
    logic        w_dec_lui_sel;
    logic [1:0]  w_dec_alu_op;
    logic [3:0]  w_dec_load_type;
    logic        w_dec_load_signed;
    logic [1:0]  w_dec_wb_sel;
    logic        w_active;

    assign w_opcode    = r_ir[6:0];
    assign w_funct3    = r_ir[14:12];
    assign w_unused_ir = ^{r_ir[31:15], r_ir[11:7]};

    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_taken = i_br_eq;
            3'b001:  w_taken = ~i_br_eq;
            3'b100:  w_taken = i_br_lt;
            3'b101:  w_taken = ~i_br_lt;
            3'b110:  w_taken = i_br_lt;
            3'b111:  w_taken = ~i_br_lt;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_is_br           = 1'b0;
        w_is_ld           = 1'b0;
        w_is_st           = 1'b0;
        w_bad             = 1'b0;
        w_dec_pc_sel      = 1'b0;
        w_dec_imm_sel     = 4'b0000;
        w_dec_br_un       = 1'b0;
        w_dec_a_sel       = 1'b0;
        w_dec_b_sel       = 1'b0;
        w_dec_lui_sel     = 1'b0;
        w_dec_alu_op      = 2'b00;
        w_dec_load_type   = 4'b0000;
        w_dec_load_signed = 1'b0;
        w_dec_wb_sel      = 2'b00;
        case (w_opcode)
            OP_R: begin
                w_dec_alu_op = 2'b01;
                w_dec_wb_sel = 2'b01;
            end
            OP_I: begin
                w_dec_alu_op = 2'b10;
                w_dec_b_sel  = 1'b1;
                w_dec_wb_sel = 2'b01;
            end
            OP_LUI: begin
                w_dec_lui_sel = 1'b1;
                w_dec_b_sel   = 1'b1;
                w_dec_imm_sel = 4'b1000;
                w_dec_wb_sel  = 2'b01;
            end
            OP_AUIPC: begin
                w_dec_a_sel   = 1'b1;
                w_dec_b_sel   = 1'b1;
                w_dec_imm_sel = 4'b1000;
                w_dec_wb_sel  = 2'b01;
            end
            OP_JAL: begin
                w_dec_a_sel   = 1'b1;
                w_dec_b_sel   = 1'b1;
                w_dec_imm_sel = 4'b0100;
                w_dec_wb_sel  = 2'b10;
                w_dec_pc_sel  = 1'b1;
            end
            OP_JALR: begin
                w_dec_b_sel  = 1'b1;
                w_dec_wb_sel = 2'b10;
                w_dec_pc_sel = 1'b1;
            end
            OP_BR: begin
                w_is_br       = 1'b1;
                w_dec_a_sel   = 1'b1;
                w_dec_b_sel   = 1'b1;
                w_dec_imm_sel = 4'b0010;
                w_dec_br_un   = (w_funct3[2:1] == 2'b11);
                w_dec_pc_sel  = w_taken;
                w_bad         = (w_funct3[2:1] == 2'b01);
            end
            OP_LD: begin
                w_is_ld     = 1'b1;
                w_dec_b_sel = 1'b1;
                case (w_funct3)
                    3'b000: begin w_dec_load_type = 4'b0001; w_dec_load_signed = 1'b1; end
                    3'b001: begin w_dec_load_type = 4'b0011; w_dec_load_signed = 1'b1; end
                    3'b010: begin w_dec_load_type = 4'b1111; w_dec_load_signed = 1'b1; end
                    3'b100: w_dec_load_type = 4'b0001;
                    3'b101: w_dec_load_type = 4'b0011;
                    default: w_bad = 1'b1;
                endcase
            end
            OP_ST: begin
                w_is_st       = 1'b1;
                w_dec_b_sel   = 1'b1;
                w_dec_imm_sel = 4'b0001;
                w_bad         = (w_funct3 > 3'b010);
            end
            default: w_bad = 1'b1;
        endcase
    end

    // Decoded controls are only exposed while an instruction is in flight.
    assign w_active = (r_state != S_FETCH) && (r_state != S_TRAP);

    always_comb begin
        w_state_next  = r_state;
        w_wait_next   = r_wait_cnt;
        o_pc_en       = 1'b0;
        o_reg_wen     = 1'b0;
        o_mem_rw      = 1'b0;
        o_insn_vld    = 1'b0;
        o_pc_sel      = w_active & w_dec_pc_sel;
        o_imm_sel     = w_active ? w_dec_imm_sel : 4'b0000;
        o_br_un       = w_active & w_dec_br_un;
        o_a_sel       = w_active & w_dec_a_sel;
        o_b_sel       = w_active & w_dec_b_sel;
        o_lui_sel     = w_active & w_dec_lui_sel;
        o_alu_op      = w_active ? w_dec_alu_op : 2'b00;
        o_load_type   = w_active ? w_dec_load_type : 4'b0000;
        o_load_signed = w_active & w_dec_load_signed;
        o_wb_sel      = w_active ? w_dec_wb_sel : 2'b00;
        case (r_state)
            S_FETCH:  w_state_next = S_DECODE;
            S_DECODE: w_state_next = w_bad ? S_TRAP : S_EXEC;
            S_EXEC: begin
                if (w_is_br) begin
                    o_pc_en      = 1'b1;
                    o_insn_vld   = 1'b1;
                    w_state_next = S_FETCH;
                end else if (w_is_ld || w_is_st) begin
                    w_wait_next  = 8'd0;
                    w_state_next = S_MEM;
                end else begin
                    w_state_next = S_WB;
                end
            end
            S_MEM: begin
                o_mem_rw = w_is_st;
                if (i_mem_ready) begin
                    w_wait_next = 8'd0;
                    if (w_is_st) begin
                        o_pc_en      = 1'b1;
                        o_insn_vld   = 1'b1;
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_WB;
                    end
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_wait_next  = 8'd0;
                    w_state_next = S_TRAP;
                end else begin
                    w_wait_next = r_wait_cnt + 8'd1;
                end
            end
            S_WB: begin
                o_reg_wen    = 1'b1;
                o_pc_en      = 1'b1;
                o_insn_vld   = 1'b1;
                w_state_next = S_FETCH;
            end
            S_TRAP:   w_state_next = S_TRAP;
            default:  w_state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_FETCH;
            r_ir       <= 32'd0;
            r_wait_cnt <= 8'd0;
            r_illegal  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
            if (r_state == S_FETCH)
                r_ir <= i_instr;
            if (w_state_next == S_TRAP)
                r_illegal <= 1'b1;
        end
    end

    assign o_illegal = r_illegal;
    assign o_state   = r_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: stimulus queues expected commit/trap records,
// a monitor pops and checks them whenever the DUT commits or enters TRAP.
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_instr;
    logic        i_br_lt, i_br_eq, i_mem_ready;
    logic        o_pc_en, o_pc_sel, o_reg_wen, o_br_un, o_a_sel, o_b_sel, o_lui_sel;
    logic [3:0]  o_imm_sel, o_load_type;
    logic [1:0]  o_alu_op, o_wb_sel;
    logic        o_load_signed, o_mem_rw, o_insn_vld, o_illegal;
    logic [2:0]  o_state;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.MEM_TIMEOUT(16)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_instr(i_instr),
        .i_br_lt(i_br_lt), .i_br_eq(i_br_eq), .i_mem_ready(i_mem_ready),
        .o_pc_en(o_pc_en), .o_pc_sel(o_pc_sel), .o_imm_sel(o_imm_sel),
        .o_reg_wen(o_reg_wen), .o_br_un(o_br_un), .o_a_sel(o_a_sel),
        .o_b_sel(o_b_sel), .o_lui_sel(o_lui_sel), .o_alu_op(o_alu_op),
        .o_load_type(o_load_type), .o_load_signed(o_load_signed),
        .o_mem_rw(o_mem_rw), .o_wb_sel(o_wb_sel), .o_insn_vld(o_insn_vld),
        .o_illegal(o_illegal), .o_state(o_state)
    );

    typedef struct {
        string       name;
        bit          is_trap;
        int          cycles;
        int          memrw;
        logic [19:0] ctrl;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rdy_at = 0;
    bit   rdy_idle = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Order: pc_sel, reg_wen, mem_rw, wb_sel, imm_sel, alu_op, a_sel, b_sel, lui_sel, br_un, load_type, load_signed
    function automatic logic [19:0] mk(input bit pcs, input bit rw, input bit mrw, input logic [1:0] wb,
                                       input logic [3:0] imm, input logic [1:0] alu, input bit a, input bit b,
                                       input bit lui, input bit un, input logic [3:0] lt, input bit ls);
        return {pcs, rw, mrw, wb, imm, alu, a, b, lui, un, lt, ls};
    endfunction

    function automatic logic [19:0] act_ctrl();
        return {o_pc_sel, o_reg_wen, o_mem_rw, o_wb_sel, o_imm_sel, o_alu_op,
                o_a_sel, o_b_sel, o_lui_sel, o_br_un, o_load_type, o_load_signed};
    endfunction

    function automatic logic [31:0] all_outs();
        return {o_pc_en, o_pc_sel, o_imm_sel, o_reg_wen, o_br_un, o_a_sel, o_b_sel, o_lui_sel,
                o_alu_op, o_load_type, o_load_signed, o_mem_rw, o_wb_sel, o_insn_vld, o_illegal, o_state};
    endfunction

    // Memory-ready driver: raises i_mem_ready in the rdy_at-th MEM cycle (0 = never).
    initial begin
        int mc = 0;
        i_mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (o_state == 3'd3) begin
                mc++;
                i_mem_ready = (rdy_at != 0) && (mc == rdy_at);
            end else begin
                mc = 0;
                i_mem_ready = rdy_idle;
            end
        end
    end

    // Monitor: counts cycles since FETCH and checks each commit / trap entry.
    initial begin
        int   cyc = 0;
        int   mrw = 0;
        logic [2:0] prev = 3'd0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_state == 3'd0) begin
                cyc = 1;
                mrw = 0;
            end else begin
                cyc++;
            end
            mrw += int'(o_mem_rw);
            check("pc_en vs insn_vld", o_pc_en, o_insn_vld);
            if (!o_insn_vld)
                check("reg_wen outside commit", o_reg_wen, 1'b0);
            if (o_insn_vld || (o_state == 3'd7 && prev != 3'd7)) begin
                check("expectation pending", q.size() > 0, 1'b1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    $display("txn %s: state=%0d cycles=%0d mem_rw_cycles=%0d ctrl=0x%05h",
                             e.name, o_state, cyc, mrw, act_ctrl());
                    check({e.name, " trap"}, o_state == 3'd7, e.is_trap);
                    check({e.name, " cycles"}, cyc, e.cycles);
                    check({e.name, " mem_rw cycles"}, mrw, e.memrw);
                    check({e.name, " ctrl"}, act_ctrl(), e.ctrl);
                    if (e.is_trap) begin
                        check({e.name, " illegal"}, o_illegal, 1'b1);
                        check({e.name, " enables"}, {o_pc_en, o_reg_wen, o_mem_rw, o_insn_vld}, 4'b0);
                    end
                end
            end
            prev = o_state;
        end
    end

    task automatic issue(input string name, input logic [31:0] instr, input bit eq, input bit lt,
                         input int ra, input bit ri, input bit trap, input int cycles,
                         input int memrw, input logic [19:0] c);
        exp_t e;
        e.name = name; e.is_trap = trap; e.cycles = cycles; e.memrw = memrw; e.ctrl = c;
        q.push_back(e);
        i_instr = instr; i_br_eq = eq; i_br_lt = lt; rdy_at = ra; rdy_idle = ri;
    endtask

    task automatic reset_on_check();
        i_reset = 1'b1;
        #1;
        check("outputs in reset", all_outs(), 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        i_reset = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 200 && q.size() != 0; k++) begin
            @(posedge clk);
            #2;
        end
        check("transaction within budget", q.size(), 0);
        if (q.size() != 0) begin
            q.delete();
            reset_on_check();
            i_instr = 32'h00000013;
            release_reset();
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        i_reset = 1'b1;
        i_instr = 32'd0;
        i_br_eq = 1'b0;
        i_br_lt = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset outputs", all_outs(), 32'd0);

        issue("add", 32'h002081B3, 0, 0, 0, 0, 0, 4, 0, mk(0,1,0,2'b01,4'b0000,2'b01,0,0,0,0,4'b0000,0));
        release_reset();
        wait_done();
        issue("add rdy_idle", 32'h002081B3, 0, 0, 0, 1, 0, 4, 0, mk(0,1,0,2'b01,4'b0000,2'b01,0,0,0,0,4'b0000,0));
        wait_done();
        issue("beq taken", 32'h00208463, 1, 0, 0, 0, 0, 3, 0, mk(1,0,0,2'b00,4'b0010,2'b00,1,1,0,0,4'b0000,0));
        wait_done();
        issue("beq not taken", 32'h00208463, 0, 0, 0, 0, 0, 3, 0, mk(0,0,0,2'b00,4'b0010,2'b00,1,1,0,0,4'b0000,0));
        wait_done();
        issue("bltu taken", 32'h0020E463, 0, 1, 0, 0, 0, 3, 0, mk(1,0,0,2'b00,4'b0010,2'b00,1,1,0,1,4'b0000,0));
        wait_done();
        issue("bge not taken", 32'h0020D463, 0, 1, 0, 0, 0, 3, 0, mk(0,0,0,2'b00,4'b0010,2'b00,1,1,0,0,4'b0000,0));
        wait_done();
        issue("lw wait3", 32'h0040A283, 0, 0, 3, 0, 0, 7, 0, mk(0,1,0,2'b00,4'b0000,2'b00,0,1,0,0,4'b1111,1));
        wait_done();
        issue("lbu ready early", 32'h0040C283, 0, 0, 1, 1, 0, 5, 0, mk(0,1,0,2'b00,4'b0000,2'b00,0,1,0,0,4'b0001,0));
        wait_done();
        issue("jal", 32'h008000EF, 0, 0, 0, 0, 0, 4, 0, mk(1,1,0,2'b10,4'b0100,2'b00,1,1,0,0,4'b0000,0));
        wait_done();
        issue("jalr", 32'h000100E7, 0, 0, 0, 0, 0, 4, 0, mk(1,1,0,2'b10,4'b0000,2'b00,0,1,0,0,4'b0000,0));
        wait_done();
        issue("addi", 32'h00510093, 0, 0, 0, 0, 0, 4, 0, mk(0,1,0,2'b01,4'b0000,2'b10,0,1,0,0,4'b0000,0));
        wait_done();
        issue("lui", 32'h123453B7, 0, 0, 0, 0, 0, 4, 0, mk(0,1,0,2'b01,4'b1000,2'b00,0,1,1,0,4'b0000,0));
        wait_done();
        issue("auipc", 32'h12345397, 0, 0, 0, 0, 0, 4, 0, mk(0,1,0,2'b01,4'b1000,2'b00,1,1,0,0,4'b0000,0));
        wait_done();
        issue("sw wait2", 32'h0050A223, 0, 0, 2, 0, 0, 5, 2, mk(0,0,1,2'b00,4'b0001,2'b00,0,1,0,0,4'b0000,0));
        wait_done();
        issue("sw timeout", 32'h0050A223, 0, 0, 0, 0, 1, 20, 16, 20'd0);
        wait_done();
        check("timeout state", o_state, 3'd7);
        reset_on_check();

        issue("illegal ffffffff", 32'hFFFFFFFF, 0, 0, 0, 0, 1, 3, 0, 20'd0);
        release_reset();
        wait_done();
        repeat (3) @(posedge clk);
        #2;
        check("trap sticky illegal", o_illegal, 1'b1);
        check("trap sticky state", o_state, 3'd7);
        reset_on_check();

        issue("bad branch funct3", 32'h0020A463, 0, 0, 0, 0, 1, 3, 0, 20'd0);
        release_reset();
        wait_done();
        reset_on_check();

        // Load abandoned by reset while waiting in MEM: no record, so any commit is flagged.
        i_instr = 32'h0040A283; rdy_at = 0; rdy_idle = 0;
        release_reset();
        repeat (5) @(posedge clk);
        #2;
        check("abandon in MEM", o_state, 3'd3);
        reset_on_check();

        issue("add after abandon", 32'h002081B3, 0, 0, 0, 0, 0, 4, 0, mk(0,1,0,2'b01,4'b0000,2'b01,0,0,0,0,4'b0000,0));
        release_reset();
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
